// File: rtl/axi_master_if.sv
// axi_master_if: single-outstanding AXI INCR burst master driven by simple write/read/CSR commands
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

package axi_pkg;
  typedef struct packed {
    logic [`AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                   awlen;
    logic [2:0]                   awsize;
    logic [1:0]                   awburst;
    logic                         awvalid;
    logic [`AXI_DATA_WIDTH-1:0]   wdata;
    logic [`AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                         wlast;
    logic                         wvalid;
    logic                         bready;
    logic [`AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                   arlen;
    logic [2:0]                   arsize;
    logic [1:0]                   arburst;
    logic                         arvalid;
    logic                         rready;
  } s_axi_mosi_t;
  typedef struct packed {
    logic                       awready;
    logic                       wready;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       arready;
    logic [`AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic                       rvalid;
  } s_axi_miso_t;
endpackage

module axi_master_if import axi_pkg::*; #(
  parameter int DATA_W = `AXI_DATA_WIDTH,
  parameter int ADDR_W = `AXI_ADDR_WIDTH
) (
  input  logic              aclk,
  input  logic              arst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              done_o,
  output logic              err_o,
  output s_axi_mosi_t       axi_mosi_if,
  input  s_axi_miso_t       axi_miso_if
);
  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
  localparam logic [2:0] SIZE = 3'($clog2(DATA_W/8));
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic [8:0] beat_q, beat_d;
  logic err_q, err_d;
  logic last;
  assign last = beat_q == {1'b0, len_q};
  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end
  // outputs are forced idle while arst is high so a mid-burst reset drops valids immediately
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_d      = beat_q;
    err_d       = err_q;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = '0;
    rd_last     = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    axi_mosi_if = '0;
    if (!arst) begin
      case (state_q)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            beat_d  = '0;
            err_d   = 1'b0;
            state_d = cmd_write ? AW : AR;
          end
        end
        AW: begin
          axi_mosi_if.awvalid = 1'b1;
          axi_mosi_if.awaddr  = addr_q;
          axi_mosi_if.awlen   = len_q;
          axi_mosi_if.awsize  = SIZE;
          axi_mosi_if.awburst = 2'b01;
          state_d = axi_miso_if.awready ? W : AW;
        end
        W: begin
          axi_mosi_if.wvalid = wr_valid;
          axi_mosi_if.wdata  = wr_data;
          axi_mosi_if.wstrb  = '1;
          axi_mosi_if.wlast  = last;
          wr_ready = axi_miso_if.wready;
          if (wr_valid && axi_miso_if.wready) begin
            beat_d  = beat_q + 9'd1;
            state_d = last ? B : W;
          end
        end
        B: begin
          axi_mosi_if.bready = 1'b1;
          if (axi_miso_if.bvalid) begin
            err_d   = err_q | (axi_miso_if.bresp != 2'b00);
            state_d = DONE;
          end
        end
        AR: begin
          axi_mosi_if.arvalid = 1'b1;
          axi_mosi_if.araddr  = addr_q;
          axi_mosi_if.arlen   = len_q;
          axi_mosi_if.arsize  = SIZE;
          axi_mosi_if.arburst = 2'b01;
          state_d = axi_miso_if.arready ? R : AR;
        end
        R: begin
          axi_mosi_if.rready = rd_ready;
          rd_valid = axi_miso_if.rvalid;
          rd_data  = axi_miso_if.rdata;
          rd_last  = axi_miso_if.rlast;
          if (axi_miso_if.rvalid && rd_ready) begin
            beat_d  = beat_q + 9'd1;
            err_d   = err_q | (axi_miso_if.rresp != 2'b00) | (axi_miso_if.rlast != last);
            state_d = axi_miso_if.rlast ? DONE : R;
          end
        end
        DONE: begin
          done_o  = 1'b1;
          err_o   = err_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_master_if.sv
// tb_axi_master_if: directed and randomized bursts against a bench-side slave and transaction model
module tb_axi_master_if;
  import axi_pkg::*;
  localparam logic [31:0] WR_BFF0 = 32'h0000_1000;
  localparam logic [31:0] RD_BFF1 = 32'h0000_2008;
  localparam logic [31:0] CSR0    = 32'h0000_3000;
  logic aclk = 1'b0, arst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic rd_valid, rd_last, rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic done_o, err_o;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso = '0;
  int vec = 0, mis = 0;

  always #5 aclk = ~aclk;

  axi_master_if dut (
    .aclk(aclk), .arst(arst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .done_o(done_o), .err_o(err_o), .axi_mosi_if(mosi), .axi_miso_if(miso)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input int len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    @(negedge aclk);
    chk("cmd_ready_idle", cmd_ready, 1);
    step;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_len   = 8'($urandom);
  endtask

  task automatic finish_txn(input bit seen);
    if (!seen) chk("txn_timeout", 0, 1);
    miso = '0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(negedge aclk);
    chk("cmd_ready_after", cmd_ready, 1);
    chk("done_after", done_o, 0);
    step;
  endtask

  task automatic run_write(input logic [31:0] addr, input int len, input int aw_wait,
                           input bit bp, input logic [1:0] bresp, input int abort_at);
    logic [31:0] data [$];
    int wi = 0;
    bit aw_done = 0, seen = 0;
    for (int i = 0; i <= len; i++) data.push_back(bp ? $urandom : 32'hA0 + i);
    issue(1'b1, addr, len);
    for (int cyc = 1; cyc < 400 && !seen; cyc++) begin
      if (abort_at >= 0 && wi == abort_at) begin
        arst = 1'b1;
        miso = '0;
        wr_valid = 1'b0;
        @(negedge aclk);
        chk("rst_mosi_idle", mosi == '0, 1);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        step;
        arst = 1'b0;
        @(negedge aclk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_mosi_idle", mosi == '0, 1);
        chk("post_rst_done", done_o, 0);
        step;
        return;
      end
      miso.awready = cyc > aw_wait;
      miso.wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_valid     = wi <= len && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      wr_data      = wi <= len ? data[wi] : 32'h0;
      miso.bvalid  = wi == len + 1;
      miso.bresp   = bresp;
      @(negedge aclk);
      chk("awvalid", mosi.awvalid, !aw_done);
      chk("arvalid_in_wr", mosi.arvalid, 0);
      if (mosi.awvalid) begin
        chk("awaddr", mosi.awaddr, addr);
        chk("awlen", mosi.awlen, len);
        chk("awsize", mosi.awsize, 2);
        chk("awburst", mosi.awburst, 1);
      end
      if (!aw_done) chk("w_before_aw", mosi.wvalid, 0);
      if (aw_done && wi <= len) begin
        chk("wvalid", mosi.wvalid, wr_valid);
        chk("wr_ready", wr_ready, miso.wready);
      end
      if (mosi.wvalid && miso.wready) begin
        chk("wdata", mosi.wdata, data[wi]);
        chk("wlast", mosi.wlast, wi == len);
        chk("wstrb", mosi.wstrb, 4'hF);
        wi++;
      end
      if (mosi.awvalid && miso.awready) aw_done = 1;
      if (done_o) begin
        chk("wr_err", err_o, bresp != 2'b00);
        chk("wr_beats", wi, len + 1);
        if (!bp) chk("wr_done_cycle", cyc, len + 4 + aw_wait);
        seen = 1;
      end
      step;
    end
    finish_txn(seen);
  endtask

  task automatic run_read(input logic [31:0] addr, input int len, input int rlast_at,
                          input int slverr_at, input bit bp);
    logic [31:0] data [$];
    int ri = 0, rdone_cyc = 0;
    bit ar_done = 0, r_done = 0, seen = 0;
    bit exp_err = (rlast_at != len) || (slverr_at >= 0 && slverr_at <= rlast_at);
    for (int i = 0; i <= rlast_at; i++) data.push_back(bp ? $urandom : 32'h11 * (i + 1));
    issue(1'b0, addr, len);
    for (int cyc = 1; cyc < 400 && !seen; cyc++) begin
      miso.arready = 1'b1;
      rd_ready     = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      miso.rvalid  = ar_done && !r_done && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      miso.rdata   = r_done ? 32'h0 : data[ri];
      miso.rlast   = ri == rlast_at;
      miso.rresp   = ri == slverr_at ? 2'b10 : 2'b00;
      @(negedge aclk);
      chk("arvalid", mosi.arvalid, !ar_done);
      chk("awvalid_in_rd", mosi.awvalid, 0);
      if (mosi.arvalid) begin
        chk("araddr", mosi.araddr, addr);
        chk("arlen", mosi.arlen, len);
        chk("arsize", mosi.arsize, 2);
        chk("arburst", mosi.arburst, 1);
      end
      if (ar_done && !r_done) begin
        chk("rd_valid", rd_valid, miso.rvalid);
        chk("rready", mosi.rready, rd_ready);
        if (miso.rvalid) begin
          chk("rd_data", rd_data, data[ri]);
          chk("rd_last", rd_last, ri == rlast_at);
        end
        if (miso.rvalid && rd_ready) begin
          ri++;
          if (miso.rlast) begin
            r_done = 1;
            rdone_cyc = cyc;
          end
        end
      end
      if (mosi.arvalid && miso.arready) ar_done = 1;
      if (done_o) begin
        chk("rd_err", err_o, exp_err);
        chk("rd_beats", ri, rlast_at + 1);
        chk("rd_done_cycle", cyc, rdone_cyc + 1);
        seen = 1;
      end
      step;
    end
    finish_txn(seen);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_mosi", mosi == '0, 1);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_done", done_o, 0);
    chk("reset_err", err_o, 0);
    step;
    arst = 1'b0;
    @(negedge aclk);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    step;
    run_write(WR_BFF0, 3, 0, 0, 2'b00, -1);
    run_read(RD_BFF1, 1, 1, -1, 0);
    run_write(WR_BFF0 + 32'h40, 7, 5, 1, 2'b00, -1);
    run_read(RD_BFF1, 2, 0, -1, 0);
    run_read(RD_BFF1, 3, 3, 1, 1);
    run_write(CSR0, 0, 0, 0, 2'b10, -1);
    run_write(WR_BFF0, 3, 0, 0, 2'b00, 2);
    run_write(WR_BFF0, 3, 0, 0, 2'b00, -1);
    run_read(RD_BFF1, 1, 3, -1, 1);
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1)
        run_write($urandom, $urandom_range(0, 15), $urandom_range(0, 3), 1,
                  $urandom_range(0, 3) == 0 ? 2'b10 : 2'b00, -1);
      else
        run_read($urandom, $urandom_range(0, 15), 0, -1, 1);
    end
    for (int k = 0; k < 4; k++) begin
      int len = $urandom_range(0, 12);
      run_read($urandom, len, len, $urandom_range(0, 1) == 1 ? int'($urandom_range(0, 12)) : -1, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
